// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer-side request bundle and FIFO-side write bus of the arbiter.
interface fifo_write_arbiter_if #(
    parameter int num_requesters = 4,
    parameter int data_width     = 32,
    parameter int id_width       = $clog2(num_requesters)
);
    logic [num_requesters*data_width-1:0] req_data;
    logic [num_requesters-1:0]            req_valid;
    logic [num_requesters-1:0]            req_last;
    logic [num_requesters-1:0]            req_ready;
    logic [data_width-1:0]                out_data;
    logic [id_width-1:0]                  out_id;
    logic                                 out_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 grant_active;
    modport master (
        output req_data, req_valid, req_last, out_ready,
        input  req_ready, out_data, out_id, out_last, out_valid, grant_active
    );
    modport slave (
        input  req_data, req_valid, req_last, out_ready,
        output req_ready, out_data, out_id, out_last, out_valid, grant_active
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-locked sharing of one FIFO write port, beats tagged with source id.
module fifo_write_arbiter #(
    parameter int num_requesters = 4,
    parameter int data_width     = 32,
    parameter int max_beats      = 16,
    parameter int id_width       = $clog2(num_requesters)
) (
    input logic clk,
    input logic reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int cw = (max_beats > 0 && $clog2(max_beats + 1) > 1) ? $clog2(max_beats + 1) : 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t state;
    logic [id_width-1:0] grant, last_grant, winner, cand;
    logic [cw-1:0] beat_count;
    logic burst, force_rel, accept;
    always_comb begin
        winner = last_grant;
        cand = last_grant;
        // descending scan so the nearest requester after last_grant wins
        for (int k = num_requesters; k >= 1; k--) begin
            cand = id_width'((int'(last_grant) + k) % num_requesters);
            if (bus.req_valid[cand]) winner = cand;
        end
    end
    always_comb begin
        burst = (state == BURST) && !reset;
        force_rel = (max_beats != 0) && (beat_count == cw'(max_beats - 1));
        bus.out_valid = burst && bus.req_valid[grant];
        bus.out_data = burst ? bus.req_data[int'(grant)*data_width +: data_width] : '0;
        bus.out_id = burst ? grant : '0;
        bus.out_last = burst && (bus.req_last[grant] || force_rel);
        bus.req_ready = '0;
        bus.req_ready[grant] = burst && bus.out_ready;
        bus.grant_active = burst;
        accept = bus.out_valid && bus.out_ready;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last_grant <= id_width'(num_requesters - 1);
            beat_count <= '0;
        end else if (state == IDLE) begin
            if (|bus.req_valid) begin
                state <= BURST;
                grant <= winner;
                beat_count <= '0;
            end
        end else if (accept) begin
            if (bus.out_last) begin
                state <= IDLE;
                last_grant <= grant;
                beat_count <= '0;
            end else begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized producers with per-requester scoreboards and a transaction-level arbitration model.
module tb_fifo_write_arbiter;
    localparam int nr = 4;
    localparam int dw = 32;
    localparam int mb = 4;
    typedef struct {logic [dw-1:0] data; logic last;} beat_t;
    logic clk = 0;
    logic reset = 1;
    fifo_write_arbiter_if #(.num_requesters(nr), .data_width(dw)) bus ();
    fifo_write_arbiter #(.num_requesters(nr), .data_width(dw), .max_beats(mb)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    beat_t gen_q[nr][$];
    beat_t exp_q[nr][$];
    int tests = 0, fails = 0;
    int owner = -1, prev = nr - 1, cnt = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic add_burst(input int i, input int len);
        beat_t b;
        for (int n = 0; n < len; n++) begin
            b.data = $urandom;
            b.last = (n == len - 1);
            gen_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
    endtask
    task automatic step(input logic [nr-1:0] en, input logic rdy, input logic rst);
        logic [nr*dw-1:0] d;
        @(posedge clk);
        #1;
        d = '0;
        for (int i = 0; i < nr; i++) begin
            bus.req_valid[i] = en[i] && gen_q[i].size() > 0;
            bus.req_last[i] = gen_q[i].size() > 0 ? gen_q[i][0].last : 1'b0;
            if (gen_q[i].size() > 0) d[i*dw +: dw] = gen_q[i][0].data;
        end
        bus.req_data = d;
        bus.out_ready = rdy;
        reset = rst;
        @(negedge clk);
        for (int i = 0; i < nr; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) void'(gen_q[i].pop_front());
    endtask
    // Reference: owner is the requester holding the port this cycle (-1 = arbitrating).
    always @(negedge clk) begin
        int nxt;
        logic el;
        nxt = owner;
        if (reset) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_active", bus.grant_active, 0);
            chk("rst_last", bus.out_last, 0);
            chk("rst_id", bus.out_id, 0);
            chk("rst_data", bus.out_data, 0);
            nxt = -1;
            prev = nr - 1;
        end else if (owner < 0) begin
            chk("idle_active", bus.grant_active, 0);
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_ready", bus.req_ready, 0);
            cnt = 0;
            for (int k = 1; k <= nr; k++)
                if (bus.req_valid[(prev + k) % nr]) begin
                    nxt = (prev + k) % nr;
                    break;
                end
        end else begin
            chk("burst_active", bus.grant_active, 1);
            chk("burst_valid", bus.out_valid, bus.req_valid[owner]);
            chk("burst_ready", bus.req_ready, bus.out_ready ? (64'd1 << owner) : 64'd0);
            if (bus.out_valid) begin
                chk("burst_id", bus.out_id, owner);
                if (exp_q[owner].size() == 0) chk("scoreboard_empty", exp_q[owner].size(), 1);
                else begin
                    el = exp_q[owner][0].last || (cnt == mb - 1);
                    chk("beat_data", bus.out_data, exp_q[owner][0].data);
                    chk("beat_last", bus.out_last, el);
                    if (bus.out_ready) begin
                        void'(exp_q[owner].pop_front());
                        cnt++;
                        if (el) begin
                            prev = owner;
                            nxt = -1;
                        end
                    end
                end
            end
        end
        owner = nxt;
    end
    initial begin
        int left;
        logic [nr-1:0] en;
        bus.req_data = '0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.out_ready = 0;
        repeat (3) step('1, 1, 1);
        add_burst(0, 3);
        repeat (6) step('1, 1, 0);
        repeat (2) for (int i = 0; i < nr; i++) add_burst(i, 1);
        repeat (20) step('1, 1, 0);
        add_burst(2, 10);
        add_burst(3, 2);
        repeat (25) step('1, 1, 0);
        add_burst(1, 6);
        repeat (2) step('1, 1, 0);
        repeat (5) step('1, 0, 0);
        repeat (10) step('1, 1, 0);
        add_burst(1, 5);
        repeat (2) step('1, 1, 0);
        add_burst(0, 2);
        repeat (3) step(4'b1101, 1, 0);
        repeat (15) step('1, 1, 0);
        for (int i = 0; i < nr; i++) add_burst(i, 3);
        repeat (2) step('1, 1, 0);
        step('1, 1, 1);
        repeat (30) step('1, 1, 0);
        repeat (3000) begin
            for (int i = 0; i < nr; i++)
                if ($urandom_range(7) == 0 && gen_q[i].size() < 20) add_burst(i, $urandom_range(10, 1));
            for (int i = 0; i < nr; i++) en[i] = $urandom_range(4) != 0;
            step(en, $urandom_range(3) != 0, $urandom_range(499) == 0);
        end
        for (int c = 0; c < 600; c++) begin
            left = 0;
            for (int i = 0; i < nr; i++) left += gen_q[i].size();
            if (left == 0) break;
            step('1, 1, 0);
        end
        left = 0;
        for (int i = 0; i < nr; i++) left += gen_q[i].size();
        chk("drain_left", left, 0);
        repeat (2) step('1, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of a cdc_fifo among num_requesters producers in the write-clock domain.
- Grants round-robin with burst lock: once a requester is granted, it keeps the port until its last beat is accepted or max_beats beats have passed.
- Tags every beat with the source requester index so the read side can demultiplex.
- Sits between producer logic and the FIFO's write_data/write_valid/write_ready.

Parameters:
- num_requesters, 4, number of requesters; must be >= 2.
- data_width, 32, payload width per requester.
- max_beats, 16, forced-release beat count per grant; 0 disables the limit.
- id_width, $clog2(num_requesters), width of the source tag.

Ports:
- clk  input  1  single clock (FIFO write clock).
- reset  input  1  synchronous, active-high reset.
- req_data  input  num_requesters*data_width  packed payloads; requester i occupies bits [i*data_width +: data_width].
- req_valid  input  num_requesters  per-requester beat valid.
- req_last  input  num_requesters  marks the final beat of a burst.
- req_ready  output  num_requesters  beat accepted from requester i when req_valid[i] && req_ready[i].
- out_data  output  data_width  to FIFO write_data (payload part).
- out_id  output  id_width  source tag; the FIFO stores it alongside out_data.
- out_last  output  1  last beat of the grant (request last or forced release).
- out_valid  output  1  to FIFO write_valid.
- out_ready  input  1  from FIFO write_ready.
- grant_active  output  1  high while in BURST.

Behaviour:
- States: IDLE, BURST. Registers:
  - grant (id_width)
  - last_grant (id_width)
  - beat_count ($clog2(max_beats+1) bits, minimum 1)
- Reset (synchronous, any cycle, including mid-burst):
  - state=IDLE, grant=0, last_grant=num_requesters-1, beat_count=0.
  - Outputs during and immediately after reset: out_valid=0, req_ready=0, grant_active=0, out_last=0, out_id=0, out_data=0.
  - A burst in progress is abandoned; no partial-burst recovery.
- IDLE:
  - out_valid=0; req_ready all 0.
  - Winner: the first i with req_valid[i]=1, scanning from last_grant+1 upward and wrapping modulo num_requesters.
  - If any request is valid: next cycle state=BURST, grant=winner, beat_count=0.
  - Arbitration costs exactly one bubble cycle; no beat transfers in IDLE.
- BURST (all outputs combinational from grant):
  - out_valid=req_valid[grant]; out_data=req_data slice[grant]; out_id=grant.
  - req_ready[grant]=out_ready; all other req_ready=0.
  - Accept = out_valid && out_ready; on accept, beat_count += 1.
  - force = (max_beats!=0) && (beat_count==max_beats-1).
  - out_last = req_last[grant] || force.
  - On accept with out_last=1: state=IDLE, last_grant=grant, beat_count=0.
- Holding the port:
  - Granted requester deasserting req_valid mid-burst keeps the grant; out_valid drops and the port idles until it resumes.
  - No timeout on idle grants.
- Full FIFO: out_ready=0 stalls; req_ready[grant]=0, and all outputs stay stable while out_valid=1.
- Forced release: requester's next beat (its burst continuation) competes in the next IDLE arbitration. The requester's own req_last is not altered; only out_last is.
- Single requester active: re-granted every burst with a one-cycle bubble between grants.
- Equal priority after release: the just-served requester becomes lowest priority.
- Throughput: one beat per cycle within a burst when out_ready=1.

Test Plan:
- Reset, then req_valid=4'b0001, 3-beat burst (last on beat 3), out_ready=1 -> grant_active at cycle 1; out_valid at cycles 1–3; out_id=0; out_last on beat 3; IDLE at cycle 4.
- req_valid=4'b1111 continuously, 1-beat bursts -> grant order 0,1,2,3,0; each burst separated by exactly one IDLE cycle.
- max_beats=4, requester 2 sends 10 beats with no last -> out_last on beats 4 and 8; re-arbitrated each time, requester 3 served in between if valid; last on beat 10 comes from req_last.
- Burst active, out_ready held 0 for 5 cycles -> out_data/out_id/out_valid stable; req_ready all 0; beat_count unchanged; transfer resumes when out_ready=1.
- Granted requester 1 drops req_valid for 3 cycles mid-burst while requester 0 is valid -> grant stays 1; req_ready[0]=0; out_valid=0 for those cycles.
- reset asserted mid-burst on beat 2 -> next cycle out_valid=0 and grant_active=0; with all requests valid, requester 0 is granted first.
